// File: rtl/meter_pkg.sv
// meter_pkg
//   Shared definitions for the period meter and related measurement blocks.
//   Provides the measurement FSM state type and the default parameter values
//   used when a block is instantiated without overrides.
package meter_pkg;

  // Measurement FSM: IDLE waits for an arming edge, MEASURE times the input.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  // Default counter / output width in clk_in cycles.
  localparam int DEFAULT_CNT_WIDTH = 32;

  // Default synchronizer depth for asynchronous inputs.
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : meter_pkg

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings an asynchronous level into the clk_in domain through a
//   SYNC_STAGES-deep flip-flop chain, then produces registered one-cycle
//   pulses on its rising and falling transitions.
//
// Ports
//   clk_in   : sampling clock
//   reset    : asynchronous, active-high reset (clears every register)
//   async_in : level asynchronous to clk_in
//   rise     : one-cycle pulse, synchronized input went 0 -> 1
//   fall     : one-cycle pulse, synchronized input went 1 -> 0
module sync_edge_detect #(
  parameter int SYNC_STAGES = meter_pkg::DEFAULT_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: async_in enters at bit 0 and is only used once it
  // has travelled to the top bit, giving metastability time to settle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // Edge detector: compare the synchronized level with its previous value.
  // Both pulses are registered so downstream logic sees clean flop outputs;
  // they are mutually exclusive because each needs a different level.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= sync_out;
      rise   <= sync_out & ~prev_q;
      fall   <= ~sync_out & prev_q;
    end
  end

endmodule : sync_edge_detect

// File: rtl/period_meter.sv
// period_meter
//   Measures the period and high time of a slow asynchronous periodic signal
//   in clk_in cycles. Reports one period/high pair per full input cycle and
//   raises timeout when no rising edge arrives for TIMEOUT cycles.
//
// Ports
//   clk_in       : measurement clock
//   reset        : asynchronous, active-high reset
//   sig_in       : signal under measurement, asynchronous to clk_in
//   period_out   : cycles between two consecutive detected rising edges
//   high_out     : cycles from a detected rising edge to the next falling edge
//   period_valid : one-cycle pulse, period_out/high_out updated this cycle
//   timeout      : level, input has stopped toggling
module period_meter
  import meter_pkg::*;
#(
  parameter int          CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int unsigned TIMEOUT     = 100_000_000,
  parameter int          SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out,
  output logic                 period_valid,
  output logic                 timeout
);

  // Last counter value before a stall is declared.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic                 rise;
  logic                 fall;
  meter_state_t         state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  // cnt counts cycles since the rise, so the true elapsed count is cnt + 1.
  // The timeout bounds cnt at TIMEOUT - 1, so this never wraps.
  assign cnt_next = cnt + ONE;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  // Measurement FSM with its counter and registered outputs.
  // IDLE only waits for an arming rise; MEASURE times each period, latches
  // the high time on fall and publishes both on the next rise. A rise that
  // lands on the final counter value wins over the timeout, so a period of
  // exactly TIMEOUT cycles is still reported.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      high_cnt     <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= MEASURE;
            cnt     <= '0;
            timeout <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out   <= cnt_next;
            high_out     <= high_cnt;
            period_valid <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt_next;
            if (fall) begin
              high_cnt <= cnt_next;
            end
            if (cnt == LAST_CNT) begin
              timeout <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : period_meter

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Self-checking bench for period_meter. sig_in is driven on falling clock
//   edges from a per-cycle waveform, so its path through the synchronizer has
//   a fixed latency. A timestamp-based reference model turns the waveform
//   into expected outputs per cycle; table rows and hand sequences add
//   explicit checks on pulse counts, measured values and timeout timing.
module tb_period_meter;

  localparam int          W   = 32;
  localparam int          SS  = 2;
  localparam int unsigned TO  = 20;
  // Falling edges from driving a sample to seeing its effect on the outputs.
  localparam int          LAT = SS + 2;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         period_valid;
  logic         timeout;

  always #5 clk_in = ~clk_in;

  period_meter #(
    .CNT_WIDTH   (W),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] per;
    logic [W-1:0] hi;
    logic         to;
  } exp_t;

  typedef struct {
    int           high_len;
    int           low_len;
    int           n_periods;
    logic [W-1:0] exp_period;
    logic [W-1:0] exp_high;
    int           exp_count;
    logic         exp_to_seen;
  } row_t;

  int   checks = 0;
  int   errors = 0;
  bit   wave[$];
  exp_t exp_q[$];

  int           valid_count;
  logic         timeout_seen;
  int           first_to_cycle;
  logic [W-1:0] first_period;
  logic [W-1:0] last_period;
  logic [W-1:0] last_high;

  // Compare one value and report a mismatch.
  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model in timestamps: every rise/fall of the driven waveform is
  // seen at the outputs after the same fixed latency, so periods and high
  // times are plain differences of drive-cycle indices.
  function automatic void buildModel();
    bit           prev = 1'b0;
    bit           armed = 1'b0;
    int           last_rise = 0;
    logic [W-1:0] hi_latched = '0;
    exp_t         e = '{v: 1'b0, per: '0, hi: '0, to: 1'b0};
    exp_q.delete();
    for (int t = 0; t < wave.size(); t++) begin
      bit r = wave[t] && !prev;
      bit f = !wave[t] && prev;
      e.v = 1'b0;
      if (!armed) begin
        if (r) begin
          armed     = 1'b1;
          last_rise = t;
          e.to      = 1'b0;
        end
      end else if (r) begin
        e.v       = 1'b1;
        e.per     = W'(t - last_rise);
        e.hi      = hi_latched;
        last_rise = t;
      end else begin
        if (f) hi_latched = W'(t - last_rise);
        if (t - last_rise == int'(TO)) begin
          e.to  = 1'b1;
          armed = 1'b0;
        end
      end
      exp_q.push_back(e);
      prev = wave[t];
    end
  endfunction

  // Compare outputs at falling edge j against the model, and tally pulses.
  task automatic checkOutput(input int j);
    exp_t e = '{v: 1'b0, per: '0, hi: '0, to: 1'b0};
    if (j >= LAT) e = exp_q[j-LAT];
    check("period_valid", 64'(period_valid), 64'(e.v));
    check("timeout", 64'(timeout), 64'(e.to));
    check("period_out", 64'(period_out), 64'(e.per));
    check("high_out", 64'(high_out), 64'(e.hi));
    if (period_valid === 1'b1) begin
      if (valid_count == 0) first_period = period_out;
      valid_count++;
      last_period = period_out;
      last_high   = high_out;
    end
    if (timeout === 1'b1 && !timeout_seen) begin
      timeout_seen   = 1'b1;
      first_to_cycle = j;
    end
  endtask

  // Drive the current waveform one sample per cycle and check every cycle.
  task automatic applyStimulus();
    buildModel();
    valid_count    = 0;
    timeout_seen   = 1'b0;
    first_to_cycle = -1;
    first_period   = '0;
    last_period    = '0;
    last_high      = '0;
    for (int j = 0; j < wave.size(); j++) begin
      @(negedge clk_in);
      checkOutput(j);
      sig_in = wave[j];
    end
  endtask

  // Reset with sig_in low, checking that all outputs read zero.
  task automatic resetDut();
    sig_in = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset period_out", 64'(period_out), 64'd0);
    check("reset high_out", 64'(high_out), 64'd0);
    check("reset period_valid", 64'(period_valid), 64'd0);
    check("reset timeout", 64'(timeout), 64'd0);
    reset = 1'b0;
  endtask

  function automatic void addPhase(input bit level, input int len);
    for (int k = 0; k < len; k++) wave.push_back(level);
  endfunction

  row_t rows[$];

  initial begin
    // high, low, periods, period, high, pulses, timeout seen
    rows.push_back('{4, 4, 6, 32'd8,  32'd4,  6, 1'b0});
    rows.push_back('{3, 7, 5, 32'd10, 32'd3,  5, 1'b0});
    rows.push_back('{10, 10, 4, 32'd20, 32'd10, 4, 1'b0});
    rows.push_back('{2, 2, 8, 32'd4,  32'd2,  8, 1'b0});
    rows.push_back('{12, 5, 3, 32'd17, 32'd12, 3, 1'b0});

    $display("[TB] start");
    reset  = 1'b1;
    sig_in = 1'b0;

    // Table rows: n full periods, then one closing rise and a short low tail.
    foreach (rows[i]) begin
      resetDut();
      wave.delete();
      for (int p = 0; p < rows[i].n_periods; p++) begin
        addPhase(1'b1, rows[i].high_len);
        addPhase(1'b0, rows[i].low_len);
      end
      addPhase(1'b1, rows[i].high_len);
      addPhase(1'b0, LAT + 1);
      applyStimulus();
      check($sformatf("row%0d pulses", i), 64'(valid_count), 64'(rows[i].exp_count));
      check($sformatf("row%0d first period", i), 64'(first_period), 64'(rows[i].exp_period));
      check($sformatf("row%0d last period", i), 64'(last_period), 64'(rows[i].exp_period));
      check($sformatf("row%0d last high", i), 64'(last_high), 64'(rows[i].exp_high));
      check($sformatf("row%0d timeout seen", i), 64'(timeout_seen), 64'(rows[i].exp_to_seen));
    end

    // Stall: one rise then 36 low cycles, then two more periods of 8.
    resetDut();
    wave.delete();
    addPhase(1'b1, 4);
    addPhase(1'b0, 36);
    for (int p = 0; p < 2; p++) begin
      addPhase(1'b1, 4);
      addPhase(1'b0, 4);
    end
    addPhase(1'b0, LAT);
    applyStimulus();
    check("stall timeout seen", 64'(timeout_seen), 64'd1);
    check("stall timeout cycle", 64'(first_to_cycle), 64'(int'(TO) + LAT));
    check("stall pulses", 64'(valid_count), 64'd1);
    check("stall period", 64'(last_period), 64'd8);
    check("stall high", 64'(last_high), 64'd4);

    // One past the boundary: a 21-cycle period must time out instead.
    resetDut();
    wave.delete();
    addPhase(1'b1, 10);
    addPhase(1'b0, 11);
    addPhase(1'b1, 4);
    addPhase(1'b0, LAT + 1);
    applyStimulus();
    check("over boundary pulses", 64'(valid_count), 64'd0);
    check("over boundary timeout cycle", 64'(first_to_cycle), 64'(int'(TO) + LAT));

    // Reset mid-measurement: sig_in high while reset is applied.
    resetDut();
    wave.delete();
    for (int p = 0; p < 3; p++) begin
      addPhase(1'b1, 4);
      addPhase(1'b0, 4);
    end
    addPhase(1'b1, 4);
    applyStimulus();
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    check("midreset period_out", 64'(period_out), 64'd0);
    check("midreset high_out", 64'(high_out), 64'd0);
    check("midreset period_valid", 64'(period_valid), 64'd0);
    check("midreset timeout", 64'(timeout), 64'd0);
    reset  = 1'b0;
    sig_in = 1'b0;
    wave.delete();
    for (int p = 0; p < 3; p++) begin
      addPhase(1'b1, 4);
      addPhase(1'b0, 4);
    end
    addPhase(1'b0, LAT);
    applyStimulus();
    check("post-reset pulses", 64'(valid_count), 64'd2);
    check("post-reset first period", 64'(first_period), 64'd8);

    // Random phases, occasionally long enough to time out.
    for (int run = 0; run < 4; run++) begin
      resetDut();
      wave.delete();
      while (wave.size() < 400) begin
        int h = $urandom_range(9, 2);
        int l = ($urandom_range(4, 0) == 0) ? $urandom_range(30, 15) : $urandom_range(9, 2);
        addPhase(1'b1, h);
        addPhase(1'b0, l);
      end
      addPhase(1'b0, LAT);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_period_meter
